// File: rtl/bias_stream_fetch.sv
// ---------------------------------------------------------------------------
// bias_stream_fetch
//
// Streams num_ch consecutive bias words out of an external synchronous bias
// ROM (read latency ROM_LAT cycles), sign-extends each word to OUT_W bits and
// presents it on a valid/ready interface together with its channel index.
// A small credit-controlled FIFO (depth ROM_LAT+1) absorbs returning reads so
// the output side can stall at any time without losing data.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle request, only honoured in IDLE
//   base_addr   ROM address of channel 0 bias (latched on start)
//   num_ch      number of biases to stream (latched on start, 0 allowed)
//   rom_en      ROM read enable (high only in issue cycles)
//   rom_addr    ROM read address (holds last issued address otherwise)
//   rom_data    ROM read data, valid ROM_LAT cycles after rom_en
//   bias_valid  output word valid (FIFO not empty)
//   out_ready   downstream ready
//   bias_data   sign-extended bias word (FIFO head)
//   bias_ch     channel index of bias_data
//   busy        high from accepted start until the done cycle
//   done        one-cycle pulse after the final word is accepted
// ---------------------------------------------------------------------------
module bias_stream_fetch #(
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 16,
    parameter int ADDR_W  = 8,
    parameter int CH_W    = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CH_W-1:0]   num_ch,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              bias_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  bias_data,
    output logic [CH_W-1:0]   bias_ch,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = ROM_LAT + 1;
    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_V = SUM_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;

    logic [ADDR_W-1:0]   base_r;
    logic [CH_W-1:0]     num_ch_r;
    logic [CH_W-1:0]     issue_cnt_r;
    logic [CH_W-1:0]     acc_cnt_r;
    logic [CH_W-1:0]     wr_ch_r;
    logic [ADDR_W-1:0]   addr_hold_r;
    logic [ROM_LAT-1:0]  tag_r;
    logic [CNT_W-1:0]    inflight_r;
    logic [CNT_W-1:0]    fifo_cnt_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [OUT_W-1:0]    mem_data_r [DEPTH];
    logic [CH_W-1:0]     mem_ch_r   [DEPTH];
    logic                busy_r;
    logic                done_r;

    logic                accept_s;
    logic                issue_s;
    logic                last_issue_s;
    logic                push_s;
    logic                pop_s;
    logic                drain_done_s;
    logic [SUM_W-1:0]    occ_s;
    logic [ADDR_W-1:0]   issue_addr_s;

    // Two's-complement sign extension of a ROM word to the output width.
    function automatic logic [OUT_W-1:0] sext(input logic [DATA_W-1:0] d);
        logic signed [OUT_W-1:0] w;
        w = OUT_W'($signed(d));
        return w;
    endfunction

    // Circular pointer increment for a FIFO whose depth need not be 2^n.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Handshake, credit and termination conditions.
    // The credit test subtracts a same-cycle pop: the slot it frees is
    // available before any newly issued read can land, which is what lets
    // the stream sustain one word per cycle while fifo + inflight never
    // exceeds DEPTH after the edge.
    always_comb begin
        accept_s     = (state_r == ST_IDLE) && start;
        pop_s        = (fifo_cnt_r != {CNT_W{1'b0}}) && out_ready;
        push_s       = tag_r[ROM_LAT-1];
        occ_s        = SUM_W'(fifo_cnt_r) + SUM_W'(inflight_r) - SUM_W'(pop_s);
        issue_s      = (state_r == ST_FETCH) && (occ_s < DEPTH_V);
        last_issue_s = issue_s && (issue_cnt_r == (num_ch_r - CH_W'(1)));
        issue_addr_s = base_r + ADDR_W'(issue_cnt_r);
        drain_done_s = (inflight_r == {CNT_W{1'b0}}) &&
                       (fifo_cnt_r == {CNT_W{1'b0}}) &&
                       (acc_cnt_r == num_ch_r);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_ch == {CH_W{1'b0}}) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (last_issue_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: read strobe/address and FIFO head presentation.
    always_comb begin
        rom_en     = issue_s;
        if (issue_s) begin
            rom_addr = issue_addr_s;
        end else begin
            rom_addr = addr_hold_r;
        end
        bias_valid = (fifo_cnt_r != {CNT_W{1'b0}});
        bias_data  = mem_data_r[rd_ptr_r];
        bias_ch    = mem_ch_r[rd_ptr_r];
        busy       = busy_r;
        done       = done_r;
    end

    // busy/done registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_FETCH) || (state_s == ST_DRAIN);
            done_r <= (state_s == ST_FIN);
        end
    end

    // Run parameters and issue/accept/write-channel counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r      <= {ADDR_W{1'b0}};
            num_ch_r    <= {CH_W{1'b0}};
            issue_cnt_r <= {CH_W{1'b0}};
            acc_cnt_r   <= {CH_W{1'b0}};
            wr_ch_r     <= {CH_W{1'b0}};
            addr_hold_r <= {ADDR_W{1'b0}};
        end else begin
            if (accept_s) begin
                base_r      <= base_addr;
                num_ch_r    <= num_ch;
                issue_cnt_r <= {CH_W{1'b0}};
                acc_cnt_r   <= {CH_W{1'b0}};
                wr_ch_r     <= {CH_W{1'b0}};
            end else begin
                if (issue_s) begin
                    issue_cnt_r <= issue_cnt_r + CH_W'(1);
                    addr_hold_r <= issue_addr_s;
                end
                if (pop_s) begin
                    acc_cnt_r <= acc_cnt_r + CH_W'(1);
                end
                if (push_s) begin
                    wr_ch_r <= wr_ch_r + CH_W'(1);
                end
            end
        end
    end

    // Return tag pipe and count of reads issued but not yet written back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_r      <= {ROM_LAT{1'b0}};
            inflight_r <= {CNT_W{1'b0}};
        end else begin
            tag_r[0] <= issue_s;
            for (int k = 1; k < ROM_LAT; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
            inflight_r <= inflight_r + CNT_W'(issue_s) - CNT_W'(push_s);
        end
    end

    // Output FIFO: pushes tagged ROM data, pops on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                mem_data_r[k] <= {OUT_W{1'b0}};
                mem_ch_r[k]   <= {CH_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= sext(rom_data);
                mem_ch_r[wr_ptr_r]   <= wr_ch_r;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            fifo_cnt_r <= fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

endmodule

// File: tb/tb_bias_stream_fetch.sv
module tb_bias_stream_fetch;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  num_ch;
    logic        out_ready;

    logic        rom_en1, rom_en2;
    logic [7:0]  rom_addr1, rom_addr2;
    logic [7:0]  rom_data1, rom_data2;
    logic        valid1, valid2;
    logic [15:0] data1, data2;
    logic [7:0]  ch1, ch2;
    logic        busy1, busy2;
    logic        done1, done2;

    logic [7:0]  rom2_q1;

    logic        sel;
    logic        m_en, m_valid, m_busy, m_done;
    logic [7:0]  m_addr, m_ch;
    logic [15:0] m_data;

    int chk_cnt;
    int pass_cnt;

    bias_stream_fetch #(.DATA_W(8), .OUT_W(16), .ADDR_W(8), .CH_W(8), .ROM_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_ch(num_ch),
        .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .bias_valid(valid1), .out_ready(out_ready), .bias_data(data1), .bias_ch(ch1),
        .busy(busy1), .done(done1)
    );

    bias_stream_fetch #(.DATA_W(8), .OUT_W(16), .ADDR_W(8), .CH_W(8), .ROM_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_ch(num_ch),
        .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .bias_valid(valid2), .out_ready(out_ready), .bias_data(data2), .bias_ch(ch2),
        .busy(busy2), .done(done2)
    );

    assign m_en    = sel ? rom_en2   : rom_en1;
    assign m_addr  = sel ? rom_addr2 : rom_addr1;
    assign m_valid = sel ? valid2    : valid1;
    assign m_data  = sel ? data2     : data1;
    assign m_ch    = sel ? ch2       : ch1;
    assign m_busy  = sel ? busy2     : busy1;
    assign m_done  = sel ? done2     : done1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word i holds i-4, except two sign-extension probes.
    function automatic logic [7:0] rom_init(input logic [7:0] a);
        case (a)
            8'h20:   return 8'h80;
            8'h21:   return 8'h7F;
            default: return a - 8'd4;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input logic [7:0] a);
        logic [7:0] d;
        d = rom_init(a);
        return {{8{d[7]}}, d};
    endfunction

    function automatic logic ready_at(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return (c % 3) == 0;
    endfunction

    // ROM models: latency 1 for u_dut, latency 2 for u_dut2.
    always @(posedge clk) begin
        if (rom_en1) rom_data1 <= rom_init(rom_addr1);
        if (rom_en2) rom2_q1   <= rom_init(rom_addr2);
        rom_data2 <= rom2_q1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  num;
        int          mode;       // 0: ready always, 1: ready 1,0,0,1,...
        int          dsel;       // 0: ROM_LAT=1 instance, 1: ROM_LAT=2 instance
        int          restart_c;  // cycle of a second start pulse (0 = none)
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        int          exp_en;     // cycle of first rom_en (-1 = never)
        int          exp_val;    // cycle of first bias_valid (-1 = never)
        int          exp_done;   // cycle of done (-1 = not checked)
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        int acc, en_n, first_en, first_val, done_c, done_n, viol, fm;
        logic stall;
        logic [15:0] hd;
        logic [7:0]  hc;
        logic [7:0]  ea;
        @(negedge clk);
        sel       = (v.dsel != 0);
        start     = 1'b1;
        base_addr = v.base;
        num_ch    = v.num;
        out_ready = 1'b1;
        acc = 0; en_n = 0; first_en = -1; first_val = -1; done_c = -1;
        done_n = 0; viol = 0; fm = 0; stall = 1'b0; hd = 16'h0000; hc = 8'h00;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            start     = (c == v.restart_c);
            base_addr = start ? 8'h40 : v.base;
            num_ch    = start ? 8'd2 : v.num;
            out_ready = ready_at(v.mode, c);
            #1;
            if (m_en) begin
                if (first_en < 0) first_en = c;
                ea = v.base + 8'(en_n);
                chk("rom_addr", {24'h0, m_addr}, {24'h0, ea});
                en_n++;
            end
            if (stall) chk("head_hold", {8'h0, m_ch, m_data}, {8'h0, hc, hd});
            if (m_valid) begin
                if (first_val < 0) first_val = c;
                if (out_ready) begin
                    chk("bias_data", {16'h0, m_data}, {16'h0, exp_word(v.base + 8'(acc))});
                    chk("bias_ch", {24'h0, m_ch}, 32'(acc));
                    if (acc == 0) chk("first_word", {16'h0, m_data}, {16'h0, v.exp_first});
                    if (acc == int'(v.num) - 1) chk("last_word", {16'h0, m_data}, {16'h0, v.exp_last});
                    acc++;
                end
            end
            stall = m_valid && !out_ready;
            hd = m_data;
            hc = m_ch;
            if (int'(u_dut2.fifo_cnt_r) > fm) fm = int'(u_dut2.fifo_cnt_r);
            if (m_done) begin
                done_n++;
                if (done_c < 0) begin
                    done_c = c;
                    chk("busy_at_done", {31'h0, m_busy}, 32'h0);
                end
            end
            if (done_c >= 0 && c > done_c && (m_busy || m_en)) viol++;
            if (done_c >= 0 && c == done_c + 3) break;
        end
        chk("run_timeout", {31'h0, done_c >= 0}, 32'h1);
        chk("words", 32'(acc), {24'h0, v.num});
        chk("issues", 32'(en_n), {24'h0, v.num});
        chk("first_en_cycle", 32'(first_en), 32'(v.exp_en));
        chk("first_valid_cycle", 32'(first_val), 32'(v.exp_val));
        chk("done_pulses", 32'(done_n), 32'h1);
        chk("idle_after_done", 32'(viol), 32'h0);
        if (v.exp_done >= 0) chk("done_cycle", 32'(done_c), 32'(v.exp_done));
        if (v.dsel != 0) chk("fifo_max_le_3", {31'h0, fm <= 3}, 32'h1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 50 && (busy1 || busy2 || done1 || done2)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {31'h0, n < 50}, 32'h1);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_en"},     {31'h0, rom_en1},    32'h0);
        chk({tag, "_rom_addr"},   {24'h0, rom_addr1},  32'h0);
        chk({tag, "_bias_valid"}, {31'h0, valid1},     32'h0);
        chk({tag, "_bias_data"},  {16'h0, data1},      32'h0);
        chk({tag, "_bias_ch"},    {24'h0, ch1},        32'h0);
        chk({tag, "_busy"},       {31'h0, busy1},      32'h0);
        chk({tag, "_done"},       {31'h0, done1},      32'h0);
    endtask

    initial begin
        vec_t rv;
        int acc;
        chk_cnt = 0; pass_cnt = 0;
        sel = 1'b0; start = 1'b0; base_addr = 8'h00; num_ch = 8'h00; out_ready = 1'b1;
        rst_n = 1'b1;

        //            base   num  mode sel rst  first     last     en  val done
        vecs[0] = '{8'h10, 8'd4, 0, 0, 0, 16'h000C, 16'h000F, 1, 3, 8};   // basic
        vecs[1] = '{8'h20, 8'd2, 0, 0, 0, 16'hFF80, 16'h007F, 1, 3, 6};   // sign ext
        vecs[2] = '{8'hFE, 8'd3, 0, 0, 0, 16'hFFFA, 16'hFFFC, 1, 3, 7};   // addr wrap
        vecs[3] = '{8'h33, 8'd0, 0, 0, 0, 16'h0000, 16'h0000, -1, -1, 1}; // zero
        vecs[4] = '{8'h08, 8'd6, 1, 1, 0, 16'h0004, 16'h0009, 1, 4, -1};  // backpressure
        vecs[5] = '{8'h30, 8'd4, 0, 0, 2, 16'h002C, 16'h002F, 1, 3, 8};   // start busy
        vecs[6] = '{8'h10, 8'd4, 0, 0, 8, 16'h000C, 16'h000F, 1, 3, 8};   // start in FIN

        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            wait_idle();
            run_vec(vecs[i]);
        end

        // Reset in the middle of a run after two words were accepted.
        wait_idle();
        sel = 1'b0;
        start = 1'b1; base_addr = 8'h50; num_ch = 8'd5; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        for (int n = 0; n < 20 && acc < 2; n++) begin
            @(negedge clk);
            #1;
            if (valid1 && out_ready) acc++;
        end
        chk("midrun_two_accepted", 32'(acc), 32'h2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrun");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rv = '{8'h50, 8'd5, 0, 0, 0, 16'h004C, 16'h0050, 1, 3, 9};
        run_vec(rv);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
